tilt_bar: RTL and testbench

TILT_BAR -- requirements
Module: tilt_bar

---
 rtl/tilt_bar.sv | 97 +++++++++
 tb/tb_tilt_bar.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/tilt_bar.sv
// tilt_bar: averages signed tilt samples and drives an LED dot/bar indicator with a sample watchdog and fault state.
// Ports: clk, reset_i (async, active-high); sample_i/sample_valid_i/sample_err_i upstream samples and bus error pulse;
// led_o (bit 0 = most negative tilt), error_led_o (fault), avg_o/avg_valid_o last average and its update pulse.
module tilt_bar #(
  parameter int N_LED    = 9,
  parameter int DATA_W   = 16,
  parameter int AVG_LOG2 = 2,
  parameter int SHIFT    = 8,
  parameter int TIMEOUT  = 1000000,
  parameter int BAR_MODE = 0
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  input  logic              sample_err_i,
  output logic [N_LED-1:0]  led_o,
  output logic              error_led_o,
  output logic [DATA_W-1:0] avg_o,
  output logic              avg_valid_o
);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int C     = (N_LED - 1) / 2;
  typedef enum logic [1:0] {S_WAIT, S_RUN, S_FAULT} state_t;
  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, sum;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [N_LED-1:0]  led_q, led_d, led_new;
  logic [DATA_W-1:0] avg_q, avg_d, avg_new;
  logic              avg_valid_q, avg_valid_d;
  logic              accept, done, timeout;
  logic signed [31:0] step, step_c, pos, lo, hi;
  always_comb begin
    accept  = sample_valid_i && !sample_err_i;
    sum     = acc_q + ACC_W'($signed(sample_i));
    done    = accept && cnt_q == CNT_W'((1 << AVG_LOG2) - 1);
    timeout = !sample_valid_i && state_q != S_FAULT && wd_q == WD_W'(TIMEOUT - 1);
    // floor division of the exact-width sum always fits back into DATA_W
    avg_new = DATA_W'($signed(sum) >>> AVG_LOG2);
    step    = 32'($signed(avg_new) >>> SHIFT);
    step_c  = step > C ? C : (step < -C ? -C : step);
    pos     = C + step_c;
    lo      = pos < C ? pos : C;
    hi      = pos < C ? C : pos;
    for (int i = 0; i < N_LED; i++)
      led_new[i] = (BAR_MODE != 0) ? (i >= lo && i <= hi) : (i == pos);
  end
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    led_d       = led_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    wd_d        = (accept || state_q == S_FAULT) ? '0 : wd_q + 1'b1;
    if (sample_err_i || timeout) begin
      state_d = S_FAULT;
      led_d   = '0;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (accept) begin
      // the accumulator is already clear in FAULT, so a sample there starts a fresh average
      acc_d       = done ? '0 : sum;
      cnt_d       = done ? '0 : cnt_q + 1'b1;
      avg_d       = done ? avg_new : avg_q;
      led_d       = done ? led_new : led_q;
      avg_valid_d = done;
      state_d     = done ? S_RUN : (state_q == S_FAULT ? S_WAIT : state_q);
    end
  end
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_WAIT;
      acc_q       <= '0;
      cnt_q       <= '0;
      wd_q        <= '0;
      led_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      led_q       <= led_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
    end
  end
  assign led_o       = led_q;
  assign avg_o       = avg_q;
  assign avg_valid_o = avg_valid_q;
  assign error_led_o = state_q == S_FAULT;
endmodule

// File: tb/tb_tilt_bar.sv
// tb_tilt_bar: scoreboard bench driving a dot-mode and a bar-mode tilt_bar with the same sample stream.
module tb_tilt_bar;
  logic clk = 1'b0;
  logic reset_i = 1'b0;
  logic [15:0] sample_i = '0;
  logic sample_valid_i = 1'b0;
  logic sample_err_i = 1'b0;
  logic [8:0] led0, led1;
  logic err0, err1, av0, av1;
  logic [15:0] avg0, avg1;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [15:0] avg;
    logic [8:0]  dot;
    logic [8:0]  bar;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  tilt_bar #(.N_LED(9), .DATA_W(16), .AVG_LOG2(2), .SHIFT(8), .TIMEOUT(100), .BAR_MODE(0)) u_dot (
    .clk(clk), .reset_i(reset_i), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .sample_err_i(sample_err_i), .led_o(led0), .error_led_o(err0), .avg_o(avg0), .avg_valid_o(av0));
  tilt_bar #(.N_LED(9), .DATA_W(16), .AVG_LOG2(2), .SHIFT(8), .TIMEOUT(100), .BAR_MODE(1)) u_bar (
    .clk(clk), .reset_i(reset_i), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .sample_err_i(sample_err_i), .led_o(led1), .error_led_o(err1), .avg_o(avg1), .avg_valid_o(av1));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic put(input logic [15:0] v);
    @(negedge clk);
    sample_i = v;
    sample_valid_i = 1'b1;
    sample_err_i = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_valid_i = 1'b0;
      sample_err_i = 1'b0;
    end
  endtask
  task automatic fin(input logic [15:0] v, input logic [15:0] a, input logic [8:0] d, input logic [8:0] b);
    exp_t e;
    e.avg = a;
    e.dot = d;
    e.bar = b;
    put(v);
    sb.push_back(e);
    idle(2);
    chk("avg_valid_one_cycle_dot", {31'd0, av0}, 0);
    chk("avg_valid_one_cycle_bar", {31'd0, av1}, 0);
  endtask
  task automatic quad(input logic [15:0] v, input logic [15:0] a, input logic [8:0] d, input logic [8:0] b);
    put(v);
    put(v);
    put(v);
    fin(v, a, d, b);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!reset_i && (av0 || av1)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_avg_valid: got dot=%0b bar=%0b expected no pulse", av0, av1);
      end else begin
        e = sb.pop_front();
        chk("avg_valid_dot", {31'd0, av0}, 1);
        chk("avg_valid_bar", {31'd0, av1}, 1);
        chk("avg_dot", {16'd0, avg0}, {16'd0, e.avg});
        chk("avg_bar", {16'd0, avg1}, {16'd0, e.avg});
        chk("led_dot", {23'd0, led0}, {23'd0, e.dot});
        chk("led_bar", {23'd0, led1}, {23'd0, e.bar});
      end
    end
  end
  initial begin
    #1 reset_i = 1'b1;
    #3;
    chk("reset_led", {23'd0, led0}, 0);
    chk("reset_err", {31'd0, err0}, 0);
    chk("reset_avg", {16'd0, avg0}, 0);
    chk("reset_avg_valid", {31'd0, av0}, 0);
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    quad(16'h0000, 16'h0000, 9'b000010000, 9'b000010000);
    quad(16'h0300, 16'h0300, 9'b010000000, 9'b011110000);
    put(16'hFFFF);
    put(16'hFFFF);
    put(16'hFFFF);
    fin(16'hFFFE, 16'hFFFE, 9'b000001000, 9'b000011000);
    quad(16'h8000, 16'h8000, 9'b000000001, 9'b000011111);
    chk("hold_led", {23'd0, led0}, 9'b000000001);
    chk("hold_avg", {16'd0, avg0}, 16'h8000);
    // one sample-free edge has already passed since the last sample
    idle(98);
    chk("no_fault_at_99", {31'd0, err0}, 0);
    idle(1);
    chk("fault_at_100_err", {31'd0, err0}, 1);
    chk("fault_led_dot", {23'd0, led0}, 0);
    chk("fault_led_bar", {23'd0, led1}, 0);
    chk("fault_avg_kept", {16'd0, avg0}, 16'h8000);
    put(16'h0300);
    idle(1);
    chk("fault_cleared", {31'd0, err0}, 0);
    chk("wait_led_zero", {23'd0, led0}, 0);
    put(16'h0300);
    put(16'h0300);
    fin(16'h0300, 16'h0300, 9'b010000000, 9'b011110000);
    put(16'h0100);
    put(16'h0100);
    @(negedge clk);
    sample_i = 16'h7FFF;
    sample_valid_i = 1'b1;
    sample_err_i = 1'b1;
    idle(1);
    chk("err_fault", {31'd0, err0}, 1);
    chk("err_led_zero", {23'd0, led0}, 0);
    chk("err_no_avg_valid", {31'd0, av0}, 0);
    chk("err_avg_kept", {16'd0, avg0}, 16'h0300);
    quad(16'h0100, 16'h0100, 9'b000100000, 9'b000110000);
    put(16'h0100);
    put(16'h0100);
    put(16'h0100);
    @(posedge clk);
    #2;
    reset_i = 1'b1;
    sample_valid_i = 1'b0;
    #1;
    chk("async_rst_led_dot", {23'd0, led0}, 0);
    chk("async_rst_led_bar", {23'd0, led1}, 0);
    chk("async_rst_avg", {16'd0, avg0}, 0);
    chk("async_rst_err", {31'd0, err0}, 0);
    chk("async_rst_avg_valid", {31'd0, av0}, 0);
    @(negedge clk);
    reset_i = 1'b0;
    put(16'h0100);
    idle(3);
    chk("post_rst_no_avg_valid", {31'd0, av0}, 0);
    chk("post_rst_avg", {16'd0, avg0}, 0);
    put(16'h0100);
    put(16'h0100);
    fin(16'h0100, 16'h0100, 9'b000100000, 9'b000110000);
    idle(2);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
